uart_rx_word: RTL
=================

UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate; BIT_CYCLES = CLK_FREQ/BAUD (integer divide), SHALL be >= 4.
REQ-003 Parameter TIMEOUT_BITS, default 20, idle bit periods after which a lone first byte is discarded.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 rx  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 word  output  16  last complete word, held until the next word completes; feeds the 16-bit scan selector's in port.
REQ-008 word_valid  output  1  one-cycle pulse when word updates.
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-011 Byte FSM states: IDLE, START, DATA, STOP; a bit counter (0..BIT_CYCLES-1) and a data index (0..7).
REQ-012 IDLE: falling edge of rxs (1 then 0) -> START, bit counter cleared.
REQ-013 START: at counter = BIT_CYCLES/2-1, rxs=0 -> DATA with counter cleared; rxs=1 -> IDLE (glitch rejected, no error).
REQ-014 DATA: each sample at counter = BIT_CYCLES-1 shifts rxs into bit[index], LSB first; after index 7 -> STOP.
REQ-015 STOP: at counter = BIT_CYCLES-1, rxs=1 accepts the byte; rxs=0 rejects it and pulses frame_err next cycle; both -> IDLE.
REQ-016 Pairing: the first accepted byte is the low byte, the second the high byte; a pair flag tracks state.
REQ-017 On the second accepted byte, word = {high, low} and word_valid pulses in the cycle after the stop sample; pair flag clears.
REQ-018 frame_err SHALL also clear the pair flag; the pending low byte is discarded and word is unchanged.
REQ-019 Timeout: while pair flag set and FSM in IDLE, a counter counts cycles; reaching TIMEOUT_BITS*BIT_CYCLES clears the pair flag; any START entry resets it.
REQ-020 word_valid and frame_err SHALL never be asserted together and never longer than one cycle.
REQ-021 Back-to-back frames (next start bit immediately after stop) SHALL be received without loss.
REQ-022 Width rules: counters sized by $clog2 of their maximum; no wrap beyond maximum (timeout counter saturates).

Reset
REQ-023 With rst_n=0 at a clock edge: FSM=IDLE, counters 0, pair flag 0, word=16'h0000, word_valid=0, frame_err=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release, reception restarts at the next falling edge only.

Structure
REQ-025 A shared package SHALL hold the FSM state typedef, DATA_BITS=8 and the BIT_CYCLES/timeout-width derivation functions.
REQ-026 One sub-module uart_rx_byte (synchronizer + byte FSM, outputs byte, byte_ok pulse, byte_err pulse); top level holds pairing, timeout and outputs.

Verification (CLK_FREQ=16, BAUD=1 -> BIT_CYCLES=16, TIMEOUT_BITS=4)
REQ-027 Send 0x34 then 0x12, clean frames -> single word_valid pulse, word=16'h1234, frame_err never set.
REQ-028 Send 0x34 with stop bit 0, then 0x12, 0x56 -> frame_err one pulse, then word=16'h5612 (0x12 is low byte).
REQ-029 Send 0xAA, idle 5 bit periods, send 0x55, 0x66 -> no word_valid after 0xAA/0x55 pair; word=16'h6655.
REQ-030 Pull rx low for 6 cycles then high -> FSM returns to IDLE, no outputs pulse; following 0x01,0x02 -> word=16'h0201.
REQ-031 Assert rst_n=0 during DATA bit 3 of a frame, release, send 0xEF,0xBE -> word=16'hBEEF, word=0 immediately after reset.
REQ-032 Stream 4 words back-to-back with zero idle gap -> 4 word_valid pulses, values match in order.

Source files
------------

// File: rtl/uart_rx_word_pkg.sv
// Shared definitions for the UART word receiver: byte FSM states, frame width
// and the parameter derivations used by the top level and the byte receiver.
package uart_rx_word_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    function automatic int calc_bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Timeout counter must be able to hold TIMEOUT_BITS*BIT_CYCLES itself (it saturates there).
    function automatic int calc_timeout_width(input int timeout_bits, input int bit_cycles);
        return $clog2(timeout_bits * bit_cycles + 1);
    endfunction

endpackage

// File: rtl/uart_rx_word_byte.sv
// Byte receiver: 2-flop synchronizer plus 8N1 byte FSM. o_byte_ok/o_byte_err
// are decoded in the stop-sample cycle so the top can register them one cycle later.
module uart_rx_byte
    import uart_rx_word_pkg::*;
#(
    parameter int BIT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_ok,
    output logic       o_byte_err,
    output logic       o_idle,
    output logic       o_start
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rxs_prev;
    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;

    rx_state_t            w_state_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [IDX_W-1:0]     w_idx_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_ok;
    logic                 w_err;
    logic                 w_start;
    logic                 w_rxs;
    logic                 w_fall;

    assign w_rxs  = r_sync2;
    assign w_fall = r_rxs_prev & ~w_rxs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxs_prev <= 1'b1;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
        end else begin
            r_sync1    <= i_rx;
            r_sync2    <= r_sync1;
            r_rxs_prev <= w_rxs;
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_idx      <= w_idx_next;
            r_shift    <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_ok         = 1'b0;
        w_err        = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (w_fall) begin
                    w_state_next = ST_START;
                    w_start      = 1'b1;
                end
            end
            ST_START: begin
                // Mid start bit: a line back high here was only a glitch.
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = w_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next          = '0;
                    w_shift_next[r_idx] = w_rxs;
                    if (r_idx == IDX_LAST) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                    w_ok         = w_rxs;
                    w_err        = ~w_rxs;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_byte     = r_shift;
    assign o_byte_ok  = w_ok;
    assign o_byte_err = w_err;
    assign o_idle     = (r_state == ST_IDLE);
    assign o_start    = w_start;

endmodule

// File: rtl/uart_rx_word.sv
// UART word receiver: pairs two received bytes into a 16-bit word (low byte
// first), drops a lone low byte on a framing error or after an idle timeout.
module uart_rx_word
    import uart_rx_word_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [15:0] word,
    output logic        word_valid,
    output logic        frame_err
);

    localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD);
    localparam int TO_W       = calc_timeout_width(TIMEOUT_BITS, BIT_CYCLES);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_BITS * BIT_CYCLES);

    logic [7:0]      w_byte;
    logic            w_byte_ok;
    logic            w_byte_err;
    logic            w_idle;
    logic            w_start;

    logic            r_pair;
    logic [7:0]      r_low;
    logic [15:0]     r_word;
    logic            r_word_valid;
    logic            r_frame_err;
    logic [TO_W-1:0] r_to_cnt;

    uart_rx_byte #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx       (rx),
        .o_byte     (w_byte),
        .o_byte_ok  (w_byte_ok),
        .o_byte_err (w_byte_err),
        .o_idle     (w_idle),
        .o_start    (w_start)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pair       <= 1'b0;
            r_low        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_byte_err) begin
                r_frame_err <= 1'b1;
                r_pair      <= 1'b0;
            end else if (w_byte_ok) begin
                if (r_pair) begin
                    r_word       <= {w_byte, r_low};
                    r_word_valid <= 1'b1;
                    r_pair       <= 1'b0;
                end else begin
                    r_low  <= w_byte;
                    r_pair <= 1'b1;
                end
            end else if (r_pair && (r_to_cnt == TO_LIMIT)) begin
                r_pair <= 1'b0;
            end

            // Idle time only accumulates while a low byte waits in IDLE.
            if (!r_pair || !w_idle || w_start) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_LIMIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign word       = r_word;
    assign word_valid = r_word_valid;
    assign frame_err  = r_frame_err;

endmodule
